// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types, default sizing and chunk popcount helper for popcount_sched
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} sched_state_t;

  localparam int NREQ_D  = 4;
  localparam int WIDTH_D = 8;
  localparam int CHUNK_D = 2;

  localparam int K     = WIDTH_D / CHUNK_D;
  localparam int ID_W  = $clog2(NREQ_D);
  localparam int RES_W = $clog2(WIDTH_D + 1);

  // Callers zero-extend their CHUNK-bit slice into this fixed-width argument.
  localparam int MAX_CHUNK = 32;

  function automatic logic [5:0] popcnt_chunk(input logic [MAX_CHUNK-1:0] bits);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHUNK; i++) begin
      n = n + 6'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/popcount_rr_pick.sv
// rtl/popcount_rr_pick.sv - combinational requester picker, round-robin after 'last'
// POPCOUNT_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority instead.
module popcount_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [NREQ-1:0] pick,
  output logic [ID_W-1:0] sel,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                base;
  int                first;
  int                idx;

`ifdef POPCOUNT_SCHED_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  assign base = 0;
`else
  assign base = int'(last) + 1;
`endif

  // rot[j] is the requester j positions past the scan start, wrapping modulo NREQ.
  always_comb begin
    dbl   = {req, req};
    rot   = NREQ'(dbl >> base);
    any   = |req;
    first = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) first = j;
    end
    idx = base + first;
    if (idx >= NREQ) idx = idx - NREQ;
    sel  = any ? ID_W'(idx) : '0;
    pick = any ? (NREQ'(1) << sel) : '0;
  end

endmodule

// File: rtl/popcount_sched.sv
// rtl/popcount_sched.sv - shared multi-cycle popcount engine arbitrated between NREQ requesters
// Define POPCOUNT_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module popcount_sched
  import popcount_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int CHUNK = CHUNK_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WIDTH-1:0]      data,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [$clog2(WIDTH+1)-1:0] result
);

  localparam int K_CYC    = WIDTH / CHUNK;
  localparam int ID_BITS  = $clog2(NREQ);
  localparam int RES_BITS = $clog2(WIDTH + 1);
  localparam int CNT_BITS = (K_CYC > 1) ? $clog2(K_CYC) : 1;

  sched_state_t         state, state_nx;
  logic [ID_BITS-1:0]   last, id, sel;
  logic [NREQ-1:0]      pick;
  logic                 any;
  logic                 accept;
  logic [CNT_BITS-1:0]  cnt;
  logic [WIDTH-1:0]     shift;
  logic [RES_BITS-1:0]  acc, acc_nx;

  popcount_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_BITS)
  ) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .sel  (sel),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = '0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          grant    = pick;
          accept   = 1'b1;
          state_nx = COUNT;
        end
      end
      COUNT:   if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign acc_nx = acc + RES_BITS'(popcnt_chunk(MAX_CHUNK'(shift[CHUNK-1:0])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last    <= ID_BITS'(NREQ - 1);
      id      <= '0;
      cnt     <= '0;
      shift   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      result  <= '0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      if (accept) begin
        shift <= data[int'(sel)*WIDTH +: WIDTH];
        acc   <= '0;
        id    <= sel;
        last  <= sel;
        cnt   <= CNT_BITS'(K_CYC - 1);
      end else if (state == COUNT) begin
        acc   <= acc_nx;
        shift <= shift >> CHUNK;
        if (cnt != '0) begin
          cnt <= cnt - CNT_BITS'(1);
        end else begin
          // Published on the edge into DONE; held until the next DONE.
          result  <= acc_nx;
          done_id <= id;
        end
      end
    end
  end

endmodule
